// File: rtl/bus_pkg.sv
// Shared definitions for the bus controller: FSM states, E-clock period
// defaults and the byte-lane helpers used by the cycle sequencer.
package bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_STROBE,
      ST_WAIT,
      ST_LATCH,
      ST_VSYNC,
      ST_VCYC,
      ST_END
   } bus_state_t;

   localparam int unsigned E_LOW_DEFAULT  = 6;
   localparam int unsigned E_HIGH_DEFAULT = 4;

   // Returns {UDS, LDS}; even byte addresses live on the upper data lane.
   function automatic logic [1:0] lane_sel(input logic word, input logic a0);
      if (word) return 2'b11;
      return a0 ? 2'b01 : 2'b10;
   endfunction

   function automatic logic [15:0] read_lane(input logic [15:0] d, input logic word,
                                             input logic a0);
      if (word) return d;
      return a0 ? {8'h00, d[7:0]} : {8'h00, d[15:8]};
   endfunction

endpackage

// File: rtl/e_clock_gen.sv
// Free-running E peripheral clock: low for LOW_CYCLES, high for HIGH_CYCLES,
// with a strobe marking the final high count of each period.
module e_clock_gen
   import bus_pkg::*;
#(
   parameter int unsigned LOW_CYCLES  = E_LOW_DEFAULT,
   parameter int unsigned HIGH_CYCLES = E_HIGH_DEFAULT
) (
   input  logic CLK,
   input  logic RESET,
   output logic E,
   output logic last_high
);

   localparam int unsigned PERIOD = LOW_CYCLES + HIGH_CYCLES;
   localparam int unsigned CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;

   logic [CW-1:0] r_cnt;
   logic          r_e;
   logic [CW-1:0] w_cnt_next;

   assign w_cnt_next = (r_cnt == CW'(PERIOD - 1)) ? '0 : r_cnt + CW'(1);

   // E is registered from the next count so it stays aligned with r_cnt.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_cnt <= '0;
         r_e   <= 1'b0;
      end else begin
         r_cnt <= w_cnt_next;
         r_e   <= (w_cnt_next >= CW'(LOW_CYCLES));
      end
   end

   assign E         = r_e;
   assign last_high = (r_cnt == CW'(PERIOD - 1));

endmodule

// File: rtl/bus_controller.sv
// Bus controller: runs 68000-style asynchronous (DTACK) and E-synchronous
// (VPA/VMA) bus cycles on behalf of a single core request port.
module bus_controller
   import bus_pkg::*;
#(
   parameter int unsigned E_LOW_CYCLES  = E_LOW_DEFAULT,
   parameter int unsigned E_HIGH_CYCLES = E_HIGH_DEFAULT
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        req,
   input  logic        req_write,
   input  logic        req_word,
   input  logic [31:0] req_addr,
   input  logic [2:0]  req_fc,
   input  logic [15:0] req_wdata,
   output logic        ack,
   output logic        err,
   output logic [15:0] rdata,
   output logic        busy,
   output logic [30:0] A,
   output logic [2:0]  FC,
   output logic        AS,
   output logic        UDS,
   output logic        LDS,
   output logic        RW,
   input  logic [15:0] D_in,
   output logic [15:0] D_out,
   output logic        D_oe,
   input  logic        DTACK,
   input  logic        BERR,
   input  logic        VPA,
   output logic        E,
   output logic        VMA
);

   bus_state_t  r_state;
   logic        r_write, r_word, r_a0;
   logic [30:0] r_A;
   logic [2:0]  r_FC;
   logic        r_AS, r_UDS, r_LDS, r_RW, r_doe, r_vma;
   logic        r_ack, r_err, r_busy;
   logic [15:0] r_dout, r_rdata;
   logic        w_e, w_last_high;
   logic [1:0]  w_sel;

   e_clock_gen #(
      .LOW_CYCLES (E_LOW_CYCLES),
      .HIGH_CYCLES(E_HIGH_CYCLES)
   ) u_e_clock_gen (
      .CLK      (CLK),
      .RESET    (RESET),
      .E        (w_e),
      .last_high(w_last_high)
   );

   assign w_sel = lane_sel(r_word, r_a0);

   // Outputs are registered on the transition into each state, so they are
   // valid during the cycle the state is occupied.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state <= ST_IDLE;
         r_write <= 1'b0;
         r_word  <= 1'b0;
         r_a0    <= 1'b0;
         r_A     <= '0;
         r_FC    <= '0;
         r_AS    <= 1'b0;
         r_UDS   <= 1'b0;
         r_LDS   <= 1'b0;
         r_RW    <= 1'b1;
         r_doe   <= 1'b0;
         r_vma   <= 1'b0;
         r_ack   <= 1'b0;
         r_err   <= 1'b0;
         r_busy  <= 1'b0;
         r_dout  <= '0;
         r_rdata <= '0;
      end else begin
         r_ack <= 1'b0;
         r_err <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (req) begin
                  r_write <= req_write;
                  r_word  <= req_word;
                  r_a0    <= req_addr[0];
                  if (req_word && req_addr[0]) begin
                     r_err <= 1'b1;
                  end else begin
                     r_state <= ST_ADDR;
                     r_busy  <= 1'b1;
                     r_A     <= req_addr[31:1];
                     r_FC    <= req_fc;
                     r_RW    <= ~req_write;
                     if (req_write)
                        r_dout <= req_word ? req_wdata : {2{req_wdata[7:0]}};
                  end
               end
            end
            ST_ADDR: begin
               r_state <= ST_STROBE;
               r_AS    <= 1'b1;
               r_doe   <= r_write;
               if (!r_write) {r_UDS, r_LDS} <= w_sel;
            end
            ST_STROBE: begin
               r_state        <= ST_WAIT;
               {r_UDS, r_LDS} <= w_sel;
            end
            ST_WAIT: begin
               if (BERR) begin
                  r_state <= ST_END;
                  r_err   <= 1'b1;
                  {r_AS, r_UDS, r_LDS} <= 3'b000;
               end else if (DTACK) begin
                  r_state <= ST_LATCH;
               end else if (VPA) begin
                  r_state <= ST_VSYNC;
               end
            end
            ST_LATCH: begin
               if (!r_write) r_rdata <= read_lane(D_in, r_word, r_a0);
               r_state <= ST_END;
               r_ack   <= 1'b1;
               {r_AS, r_UDS, r_LDS} <= 3'b000;
            end
            ST_VSYNC: begin
               if (BERR) begin
                  r_state <= ST_END;
                  r_err   <= 1'b1;
                  {r_AS, r_UDS, r_LDS} <= 3'b000;
               end else if (w_last_high) begin
                  r_state <= ST_VCYC;
                  r_vma   <= 1'b1;
               end
            end
            ST_VCYC: begin
               if (BERR) begin
                  r_state <= ST_END;
                  r_err   <= 1'b1;
                  r_vma   <= 1'b0;
                  {r_AS, r_UDS, r_LDS} <= 3'b000;
               end else if (w_last_high) begin
                  if (!r_write) r_rdata <= read_lane(D_in, r_word, r_a0);
                  r_state <= ST_END;
                  r_ack   <= 1'b1;
                  r_vma   <= 1'b0;
                  {r_AS, r_UDS, r_LDS} <= 3'b000;
               end
            end
            ST_END: begin
               r_state <= ST_IDLE;
               r_RW    <= 1'b1;
               r_doe   <= 1'b0;
               r_busy  <= 1'b0;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign ack   = r_ack;
   assign err   = r_err;
   assign rdata = r_rdata;
   assign busy  = r_busy;
   assign A     = r_A;
   assign FC    = r_FC;
   assign AS    = r_AS;
   assign UDS   = r_UDS;
   assign LDS   = r_LDS;
   assign RW    = r_RW;
   assign D_out = r_dout;
   assign D_oe  = r_doe;
   assign E     = w_e;
   assign VMA   = r_vma;

endmodule

// File: tb/tb_bus_controller.sv
// Self-checking bench for bus_controller: directed scenarios followed by
// randomized transactions checked cycle by cycle against a timeline model.
module tb_bus_controller;

   localparam int LOW  = 6;
   localparam int HIGH = 4;
   localparam int P    = LOW + HIGH;

   logic        CLK = 1'b0;
   logic        RESET;
   logic        req, req_write, req_word;
   logic [31:0] req_addr;
   logic [2:0]  req_fc;
   logic [15:0] req_wdata;
   logic        ack, err, busy;
   logic [15:0] rdata;
   logic [30:0] A;
   logic [2:0]  FC;
   logic        AS, UDS, LDS, RW;
   logic [15:0] D_in, D_out;
   logic        D_oe;
   logic        DTACK, BERR, VPA;
   logic        E, VMA;

   int          checks = 0;
   int          errors = 0;
   int          txn_no = 0;
   int          ecnt = 0;
   logic [15:0] exp_rdata;

   logic        r_wr, r_word;
   logic [31:0] r_addr;
   int          r_kind, r_w, r_d;
   logic        r_extra;

   bus_controller #(
      .E_LOW_CYCLES (LOW),
      .E_HIGH_CYCLES(HIGH)
   ) dut (
      .CLK(CLK), .RESET(RESET),
      .req(req), .req_write(req_write), .req_word(req_word), .req_addr(req_addr),
      .req_fc(req_fc), .req_wdata(req_wdata),
      .ack(ack), .err(err), .rdata(rdata), .busy(busy),
      .A(A), .FC(FC), .AS(AS), .UDS(UDS), .LDS(LDS), .RW(RW),
      .D_in(D_in), .D_out(D_out), .D_oe(D_oe),
      .DTACK(DTACK), .BERR(BERR), .VPA(VPA),
      .E(E), .VMA(VMA)
   );

   always #5 CLK = ~CLK;

   // Position within the E period, counted from reset release.
   always @(posedge CLK) begin
      if (RESET) ecnt <= 0;
      else       ecnt <= (ecnt + 1) % P;
   end

   task automatic chk(input string name, input int k, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s txn=%0d k=%0d observed=0x%0h expected=0x%0h",
                name, txn_no, k, obs, exp);
      end
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         chk("idle_busy", i, busy, 1'b0);
         chk("idle_AS", i, AS, 1'b0);
         chk("idle_ack", i, ack, 1'b0);
         chk("idle_err", i, err, 1'b0);
         chk("idle_RW", i, RW, 1'b1);
         chk("idle_E", i, E, ecnt >= LOW);
         chk("idle_rdata", i, rdata, exp_rdata);
      end
   endtask

   // kind: 0 DTACK, 1 BERR in WAIT, 2 VPA, 3 VPA then BERR; w = extra WAIT
   // cycles before the response; extra adds a lower-priority response.
   task automatic run_txn(input logic wr, input logic word, input logic [31:0] addr,
                          input logic [2:0] fc, input logic [15:0] wd,
                          input logic [15:0] din, input int kind, input int w,
                          input int d, input logic extra);
      int          e0, k_v, k_s, kb, k_end;
      logic        ok, vpa_path, ds;
      logic [1:0]  sel;
      logic [15:0] exp_dout, new_rdata;
      txn_no++;
      req = 1'b1; req_write = wr; req_word = word; req_addr = addr;
      req_fc = fc; req_wdata = wd;
      DTACK = 1'b0; BERR = 1'b0; VPA = 1'b0; D_in = 16'($urandom);
      e0 = ecnt;
      if (word && addr[0]) begin
         @(negedge CLK);
         chk("mis_err", 1, err, 1'b1);
         chk("mis_ack", 1, ack, 1'b0);
         chk("mis_busy", 1, busy, 1'b0);
         chk("mis_AS", 1, AS, 1'b0);
         req = 1'b0;
         @(negedge CLK);
         chk("mis_err_end", 2, err, 1'b0);
         chk("mis_AS_end", 2, AS, 1'b0);
         chk("mis_busy_end", 2, busy, 1'b0);
         return;
      end
      k_v = 4 + w;
      k_s = k_v + (P - 1 - (e0 + k_v) % P);
      kb  = 0;
      case (kind)
         0:       begin k_end = 5 + w;       ok = 1'b1; vpa_path = 1'b0; end
         1:       begin k_end = 4 + w;       ok = 1'b0; vpa_path = 1'b0; end
         2:       begin k_end = k_s + P + 1; ok = 1'b1; vpa_path = 1'b1; end
         default: begin
            kb = k_v + (d % (k_s + P - k_v + 1));
            k_end = kb + 1; ok = 1'b0; vpa_path = 1'b1;
         end
      endcase
      sel       = word ? 2'b11 : (addr[0] ? 2'b01 : 2'b10);
      exp_dout  = word ? wd : {wd[7:0], wd[7:0]};
      new_rdata = word ? din : (addr[0] ? {8'h00, din[7:0]} : {8'h00, din[15:8]});
      for (int k = 1; k <= k_end + 1; k++) begin
         @(negedge CLK);
         if (ok && !wr && k == k_end) exp_rdata = new_rdata;
         ds = wr ? (k >= 3 && k < k_end) : (k >= 2 && k < k_end);
         chk("busy", k, busy, k <= k_end);
         chk("AS", k, AS, k >= 2 && k < k_end);
         chk("UDS", k, UDS, ds && sel[1]);
         chk("LDS", k, LDS, ds && sel[0]);
         chk("RW", k, RW, (k <= k_end) ? !wr : 1'b1);
         chk("D_oe", k, D_oe, wr && k >= 2 && k <= k_end);
         if (wr && k >= 2 && k <= k_end) chk("D_out", k, D_out, exp_dout);
         if (k <= k_end) begin
            chk("A", k, A, addr[31:1]);
            chk("FC", k, FC, fc);
         end
         chk("VMA", k, VMA, vpa_path && k >= k_s + 1 && k < k_end);
         chk("ack", k, ack, ok && k == k_end);
         chk("err", k, err, !ok && k == k_end);
         chk("rdata", k, rdata, exp_rdata);
         chk("E", k, E, ((e0 + k) % P) >= LOW);
         if (k <= k_end) begin
            req = 1'($urandom); req_write = 1'($urandom); req_word = 1'($urandom);
            req_addr = $urandom; req_fc = 3'($urandom); req_wdata = 16'($urandom);
         end else begin
            req = 1'b0;
         end
         D_in = (k == k_end - 1) ? din : 16'($urandom);
         case (kind)
            0: begin
               DTACK = (k >= ((w == 0) ? 1 : 3 + w)) && k < k_end;
               VPA   = extra && k >= 3 + w && k < k_end;
               BERR  = 1'b0;
            end
            1: begin
               BERR  = (k == 3 + w);
               DTACK = extra && (k == 3 + w);
               VPA   = 1'b0;
            end
            2: begin
               VPA = k >= 3 + w && k < k_end; DTACK = 1'b0; BERR = 1'b0;
            end
            default: begin
               VPA = k >= 3 + w && k < k_end; DTACK = 1'b0; BERR = (k == kb);
            end
         endcase
      end
   endtask

   task automatic reset_in_wait();
      txn_no++;
      req = 1'b1; req_write = 1'b0; req_word = 1'b1; req_addr = 32'h0000_6000;
      req_fc = 3'd2; DTACK = 1'b0; BERR = 1'b0; VPA = 1'b0;
      for (int k = 1; k <= 12; k++) begin
         @(negedge CLK);
         chk("hang_busy", k, busy, 1'b1);
         chk("hang_AS", k, AS, k >= 2);
         chk("hang_ack", k, ack, 1'b0);
         req = 1'b0;
      end
      RESET = 1'b1;
      @(negedge CLK);
      chk("rst_AS", 13, AS, 1'b0);
      chk("rst_UDS", 13, UDS, 1'b0);
      chk("rst_LDS", 13, LDS, 1'b0);
      chk("rst_E", 13, E, 1'b0);
      chk("rst_busy", 13, busy, 1'b0);
      chk("rst_ack", 13, ack, 1'b0);
      chk("rst_err", 13, err, 1'b0);
      chk("rst_RW", 13, RW, 1'b1);
      chk("rst_rdata", 13, rdata, 16'h0000);
      chk("rst_A", 13, A, 31'h0);
      RESET = 1'b0;
      exp_rdata = 16'h0000;
      idle_cycles(4);
   endtask

   initial begin
      RESET = 1'b1; req = 1'b0; req_write = 1'b0; req_word = 1'b0; req_addr = '0;
      req_fc = '0; req_wdata = '0; D_in = '0; DTACK = 1'b0; BERR = 1'b0; VPA = 1'b0;
      exp_rdata = 16'h0000;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("reset_AS", 0, AS, 1'b0);
      chk("reset_UDS_LDS", 0, {UDS, LDS}, 2'b00);
      chk("reset_VMA", 0, VMA, 1'b0);
      chk("reset_D_oe", 0, D_oe, 1'b0);
      chk("reset_ack_err", 0, {ack, err}, 2'b00);
      chk("reset_busy", 0, busy, 1'b0);
      chk("reset_RW", 0, RW, 1'b1);
      chk("reset_A", 0, A, 31'h0);
      chk("reset_FC", 0, FC, 3'h0);
      chk("reset_D_out", 0, D_out, 16'h0000);
      chk("reset_rdata", 0, rdata, 16'h0000);
      chk("reset_E", 0, E, 1'b0);
      RESET = 1'b0;
      idle_cycles(2);

      run_txn(1'b0, 1'b1, 32'h0000_1000, 3'd5, 16'h0000, 16'hBEEF, 0, 0, 0, 1'b0);
      run_txn(1'b1, 1'b0, 32'h0000_0003, 3'd1, 16'h00A5, 16'h0000, 0, 0, 0, 1'b0);
      run_txn(1'b0, 1'b1, 32'h0000_0005, 3'd6, 16'h0000, 16'h0000, 0, 0, 0, 1'b0);
      run_txn(1'b0, 1'b1, 32'h0000_2000, 3'd5, 16'h0000, 16'h5555, 1, 1, 0, 1'b1);
      run_txn(1'b0, 1'b1, 32'h0000_4000, 3'd5, 16'h0000, 16'h1234, 2, 0, 0, 1'b0);
      run_txn(1'b0, 1'b0, 32'h0000_4001, 3'd5, 16'h0000, 16'h9A7C, 0, 2, 0, 1'b1);
      run_txn(1'b0, 1'b1, 32'h0000_8000, 3'd5, 16'h0000, 16'hDEAD, 3, 1, 7, 1'b0);
      idle_cycles(3);
      reset_in_wait();

      for (int t = 0; t < 60; t++) begin
         r_wr    = 1'($urandom);
         r_word  = 1'($urandom);
         r_addr  = $urandom;
         if (r_word && ($urandom_range(7) != 0)) r_addr[0] = 1'b0;
         r_kind  = int'($urandom_range(3));
         r_w     = int'($urandom_range(3));
         r_d     = int'($urandom_range(31));
         r_extra = 1'($urandom);
         run_txn(r_wr, r_word, r_addr, 3'($urandom), 16'($urandom), 16'($urandom),
                 r_kind, r_w, r_d, r_extra);
         if ($urandom_range(2) == 0) idle_cycles(int'($urandom_range(1, 3)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bus_controller.md
BUS_CONTROLLER -- requirements
Module: bus_controller

Interface
REQ-001 Parameter E_LOW_CYCLES, default 6, SHALL set the number of CLK cycles E is low per period.
REQ-002 Parameter E_HIGH_CYCLES, default 4, SHALL set the number of CLK cycles E is high per period.
REQ-003 Ports SHALL be, one per line (name, direction, width, meaning); all control signals are active-high (1 = asserted):
- CLK  in  1  clock
- RESET  in  1  reset: synchronous, active-high; clock CLK
- req  in  1  core bus-cycle request
- req_write  in  1  1 write, 0 read
- req_word  in  1  1 word, 0 byte
- req_addr  in  32  byte address
- req_fc  in  3  function code
- req_wdata  in  16  write data
- ack  out  1  cycle done, one-cycle pulse
- err  out  1  bus or address error, one-cycle pulse
- rdata  out  16  read data
- busy  out  1  state != IDLE
- A  out  31  address[31:1]
- FC  out  3  function code
- AS, UDS, LDS, RW  out  1 each  bus strobes; RW = 1 means read
- D_in  in  16  bus data in
- D_out  out  16  bus data out
- D_oe  out  1  D_out drive enable
- DTACK, BERR, VPA  in  1 each  bus responses
- E, VMA  out  1 each  peripheral clock and valid memory address

Function
REQ-004 The state machine SHALL have states IDLE, ADDR, STROBE, WAIT, LATCH, VSYNC, VCYC and END.
REQ-005 req SHALL be sampled only in IDLE; all req_* fields SHALL be captured on the accepting edge, and req in any other state SHALL be ignored.
REQ-006 A word request with req_addr[0]=1 SHALL start no bus cycle and SHALL pulse err for one cycle, one cycle after acceptance.
REQ-007 The valid path SHALL be IDLE -> ADDR -> STROBE -> WAIT -> LATCH -> END -> IDLE, one cycle per state except WAIT.
REQ-008 A, FC and RW SHALL be valid from ADDR through END; RW SHALL be 1 at all other times.
REQ-009 AS SHALL be asserted from STROBE through LATCH, VSYNC and VCYC, and negated in END.
REQ-010 On reads, UDS/LDS SHALL follow AS; on writes, UDS/LDS SHALL assert from WAIT and negate in END.
REQ-011 A word access SHALL assert both UDS and LDS; a byte access SHALL assert UDS when addr[0]=0 and LDS when addr[0]=1.
REQ-012 On writes, D_oe SHALL be high from STROBE through END, and a byte write SHALL drive req_wdata[7:0] on both bytes of D_out.
REQ-013 WAIT SHALL hold indefinitely until a response, with priority BERR > DTACK > VPA.
- DTACK -> LATCH
- VPA -> VSYNC
- BERR -> END with err flag set
REQ-014 Read data SHALL be captured from D_in in LATCH, or in the VCYC exit cycle on a VPA cycle.
REQ-015 A byte read SHALL return the selected byte in rdata[7:0] with rdata[15:8]=0.
REQ-016 rdata SHALL hold its value until the next successful read.
REQ-017 In END, ack SHALL pulse for a successful cycle, or err SHALL pulse for a bus error; never both.
REQ-018 With DTACK held high, a request sampled at the end of cycle 0 SHALL produce ack in cycle 5, and IDLE SHALL be re-entered in cycle 6.
REQ-019 E SHALL come from a free-running counter 0..(E_LOW_CYCLES+E_HIGH_CYCLES-1), low for counts below E_LOW_CYCLES and high otherwise.
REQ-020 VSYNC SHALL wait for the last E-high count, then enter VCYC.
REQ-021 VMA SHALL be asserted throughout VCYC.
REQ-022 VCYC SHALL exit to END on its next last-E-high count, capturing data on that cycle.
REQ-023 BERR during VSYNC or VCYC SHALL go to END with err flag set.
REQ-024 A cycle with no response SHALL hang in WAIT; no timeout is provided.

Reset
REQ-025 On RESET, the block SHALL force state IDLE, E counter 0 (E=0), AS=UDS=LDS=VMA=D_oe=ack=err=busy=0, RW=1, A=0, FC=0, D_out=0 and rdata=0.
REQ-026 RESET mid-cycle SHALL negate all strobes on the next edge and SHALL produce no ack or err.

Structure
REQ-027 The state enumeration and E period defaults SHALL reside in shared package bus_pkg.
REQ-028 The E counter/generator SHALL be sub-module e_clock_gen, which outputs E and a last_high strobe.

Verification
REQ-029 Word read, addr 0x001000, DTACK held high, D_in=0xBEEF -> A=0x000800, UDS=LDS=1, ack in cycle 5, rdata=0xBEEF.
REQ-030 Byte write, addr 0x000003, wdata=0x00A5 -> LDS only, RW=0 ADDR..END, D_out=0xA5A5, ack pulse once.
REQ-031 Word read, addr 0x000005 -> err one cycle after acceptance, AS never asserted.
REQ-032 Read with DTACK and BERR rising together in WAIT -> err pulse, no ack, rdata unchanged.
REQ-033 Read with VPA, D_in=0x1234 -> VMA asserted during VCYC only, rdata=0x1234 captured on the E high-to-low boundary, ack in the following cycle.
REQ-034 RESET asserted in WAIT -> next cycle AS=UDS=LDS=0, E=0, busy=0, no ack.
